// File: rtl/sim_console_mon.sv
// Simulation monitor: snoops AXI writes for console characters, buffers them in a FIFO,
// and raises sticky pass/fail status from write-back magic values or a no-retire watchdog.
module sim_console_mon #(
  parameter logic [31:0] CON_ADDR   = 32'h9000_0000,
  parameter int          FIFO_DEPTH = 16,
  parameter int          WD_CYC     = 5000000,
  parameter logic [63:0] PASS_VAL   = 64'h0000_0004_4433_3222,
  parameter logic [63:0] FAIL_VAL   = 64'h0000_0023_8234_8720
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         awvalid,
  input  logic         awready,
  input  logic [39:0]  awaddr,
  input  logic [3:0]   awlen,
  input  logic         wvalid,
  input  logic         wready,
  input  logic         wlast,
  input  logic [127:0] wdata,
  input  logic [15:0]  wstrb,
  input  logic         retire,
  input  logic         wb0_vld,
  input  logic         wb1_vld,
  input  logic [63:0]  wb0_data,
  input  logic [63:0]  wb1_data,
  output logic         char_valid,
  output logic [7:0]   char_data,
  input  logic         char_ready,
  output logic         status_done,
  output logic         status_pass,
  output logic [1:0]   fail_code,
  output logic [15:0]  drop_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = (WD_CYC > 2) ? $clog2(WD_CYC) : 1;

  typedef enum logic [1:0] {IDLE, W_HIT, W_MISS} state_t;

  state_t state_q, state_d;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] fifo_cnt_q, fifo_cnt_d;
  logic             char_valid_q, char_valid_d;
  logic [7:0]       char_data_q, char_data_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  logic             wb0_vld_q, wb1_vld_q;
  logic [63:0]      wb0_data_q, wb1_data_q;

  logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic             seen_q, seen_d;

  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [1:0]       code_q, code_d;

  logic             aw_hs, w_hs, aw_hit, hit_ctx;
  logic             ch_ok;
  logic [7:0]       ch_byte;
  logic [7:0]       lane [16];
  logic             push_req, push, pop, full, drop;
  logic             pass_hit, fail_hit, wd_term, wd_fire;

  // Only the low 32 address bits take part in the console decode.
  logic unused_addr_hi;
  assign unused_addr_hi = ^awaddr[39:32];

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_lane
      assign lane[gi] = wdata[8*gi +: 8];
    end
  endgenerate

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign aw_hit = (awlen == 4'd0) && (awaddr[31:0] == CON_ADDR);
  // A W beat is decoded after a hit AW, or alongside a hit AW in the same cycle.
  assign hit_ctx = (state_q == W_HIT) || ((state_q == IDLE) && aw_hs && aw_hit);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (aw_hs && !(w_hs && wlast)) begin
          state_d = aw_hit ? W_HIT : W_MISS;
        end
      end
      W_HIT, W_MISS: begin
        if (w_hs && wlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ch_ok   = 1'b0;
    ch_byte = 8'h00;
    case (wstrb)
      16'h000F: begin ch_ok = 1'b1; ch_byte = lane[0];  end
      16'h00F0: begin ch_ok = 1'b1; ch_byte = lane[4];  end
      16'h0F00: begin ch_ok = 1'b1; ch_byte = lane[8];  end
      16'hF000: begin ch_ok = 1'b1; ch_byte = lane[12]; end
      default: begin
        for (int k = 0; k < 16; k++) begin
          if (wstrb == (16'h0001 << k)) begin
            ch_ok   = 1'b1;
            ch_byte = lane[k];
          end
        end
      end
    endcase
  end

  assign push_req = w_hs && hit_ctx && ch_ok;
  assign pop      = char_valid_q && char_ready;
  assign full     = (fifo_cnt_q == CNT_W'(FIFO_DEPTH));
  assign push     = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q + PTR_W'(push);
    rd_ptr_d     = rd_ptr_q + PTR_W'(pop);
    fifo_cnt_d   = fifo_cnt_q + CNT_W'(push) - CNT_W'(pop);
    char_valid_d = 1'b0;
    char_data_d  = 8'h00;
    if (fifo_cnt_d != '0) begin
      char_valid_d = 1'b1;
      // The new head may be the byte being written this very cycle.
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        char_data_d = ch_byte;
      end else begin
        char_data_d = fifo_mem[rd_ptr_d];
      end
    end
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= ch_byte;
    end
  end

  assign pass_hit = (wb0_vld_q && (wb0_data_q == PASS_VAL)) ||
                    (wb1_vld_q && (wb1_data_q == PASS_VAL));
  assign fail_hit = (wb0_vld_q && (wb0_data_q == FAIL_VAL)) ||
                    (wb1_vld_q && (wb1_data_q == FAIL_VAL));

  assign wd_term = (wd_cnt_q == WD_W'(WD_CYC - 1));
  assign wd_fire = wd_term && !seen_q && !retire;

  always_comb begin
    wd_cnt_d = wd_term ? '0 : wd_cnt_q + WD_W'(1);
    seen_d   = wd_term ? 1'b0 : (seen_q || retire);
    done_d   = done_q;
    pass_d   = pass_q;
    code_d   = code_q;
    // Status is frozen once done; pass beats fail beats watchdog.
    if (!done_q) begin
      if (pass_hit) begin
        done_d = 1'b1;
        pass_d = 1'b1;
        code_d = 2'd0;
      end else if (fail_hit) begin
        done_d = 1'b1;
        code_d = 2'd1;
      end else if (wd_fire) begin
        done_d = 1'b1;
        code_d = 2'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      char_valid_q <= 1'b0;
      char_data_q  <= 8'h00;
      drop_cnt_q   <= 16'h0000;
      wb0_vld_q    <= 1'b0;
      wb1_vld_q    <= 1'b0;
      wb0_data_q   <= 64'h0;
      wb1_data_q   <= 64'h0;
      wd_cnt_q     <= '0;
      seen_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      code_q       <= 2'd0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
      drop_cnt_q   <= drop_cnt_d;
      wb0_vld_q    <= wb0_vld;
      wb1_vld_q    <= wb1_vld;
      wb0_data_q   <= wb0_data;
      wb1_data_q   <= wb1_data;
      wd_cnt_q     <= wd_cnt_d;
      seen_q       <= seen_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
      code_q       <= code_d;
    end
  end

  assign char_valid  = char_valid_q;
  assign char_data   = char_data_q;
  assign drop_cnt    = drop_cnt_q;
  assign status_done = done_q;
  assign status_pass = pass_q;
  assign fail_code   = code_q;

endmodule

// File: tb/tb_sim_console_mon.sv
// Self-checking bench for sim_console_mon: directed console/magic/watchdog steps plus
// randomized console traffic checked against a queue-based character model.
module tb_sim_console_mon;

  localparam logic [31:0] CON  = 32'h9000_0000;
  localparam logic [63:0] PASS = 64'h0000_0004_4433_3222;
  localparam logic [63:0] FAIL = 64'h0000_0023_8234_8720;
  localparam int          DEPTH = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         awvalid = 0, awready = 0, wvalid = 0, wready = 0, wlast = 0;
  logic [39:0]  awaddr = '0;
  logic [3:0]   awlen = '0;
  logic [127:0] wdata = '0;
  logic [15:0]  wstrb = '0;
  logic         retire = 1'b1;
  logic         wb0_vld = 0, wb1_vld = 0;
  logic [63:0]  wb0_data = '0, wb1_data = '0;
  logic         char_valid, char_ready = 1'b0;
  logic [7:0]   char_data;
  logic         status_done, status_pass;
  logic [1:0]   fail_code;
  logic [15:0]  drop_cnt;

  int checks = 0;
  int failures = 0;

  logic [7:0]  mq[$];
  int unsigned m_drop = 0;
  bit          m_push = 0;
  logic [7:0]  m_byte = '0;
  bit          rnd_ready = 0;

  sim_console_mon #(
    .CON_ADDR(CON), .FIFO_DEPTH(DEPTH), .WD_CYC(8), .PASS_VAL(PASS), .FAIL_VAL(FAIL)
  ) dut (
    .clk(clk), .rst(rst),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .wvalid(wvalid), .wready(wready), .wlast(wlast), .wdata(wdata), .wstrb(wstrb),
    .retire(retire),
    .wb0_vld(wb0_vld), .wb1_vld(wb1_vld), .wb0_data(wb0_data), .wb1_data(wb1_data),
    .char_valid(char_valid), .char_data(char_data), .char_ready(char_ready),
    .status_done(status_done), .status_pass(status_pass), .fail_code(fail_code),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Character expected from a strobe/data pair; bit 8 says whether one exists.
  function automatic logic [8:0] ref_char(input logic [15:0] s, input logic [127:0] d);
    if (s == 16'h000F) return {1'b1, d[7:0]};
    if (s == 16'h00F0) return {1'b1, d[39:32]};
    if (s == 16'h0F00) return {1'b1, d[71:64]};
    if (s == 16'hF000) return {1'b1, d[103:96]};
    if ($countones(s) == 1) begin
      for (int k = 0; k < 16; k++) begin
        if (s[k]) return {1'b1, 8'(d >> (8 * k))};
      end
    end
    return 9'h000;
  endfunction

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic step();
    bit pop, full;
    if (rnd_ready) char_ready = 1'($urandom);
    @(negedge clk);
    chk("char_valid", char_valid, (mq.size() != 0));
    if (mq.size() != 0) chk("char_data", char_data, mq[0]);
    chk("drop_cnt", drop_cnt, m_drop);
    full = (mq.size() == DEPTH);
    pop  = (mq.size() != 0) && char_ready;
    if (pop) void'(mq.pop_front());
    if (m_push) begin
      if (full && !pop) begin
        if (m_drop < 65535) m_drop++;
      end else begin
        mq.push_back(m_byte);
      end
    end
    m_push = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    awvalid = 0; awready = 0; wvalid = 0; wready = 0; wlast = 0;
    wb0_vld = 0; wb1_vld = 0; char_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    m_drop = 0;
    m_push = 0;
  endtask

  task automatic cw(input logic [39:0] a, input logic [3:0] len, input logic [15:0] s,
                    input logic [127:0] d, input bit same);
    logic [8:0] r;
    bit hit;
    r   = ref_char(s, d);
    hit = (len == 0) && (a[31:0] == CON);
    awvalid = 1; awready = 1; awaddr = a; awlen = len;
    if (!same) begin
      step();
      awvalid = 0; awready = 0;
      if ($urandom_range(2) == 0) begin
        wvalid = 1; wready = 0; wdata = d; wstrb = s;
        step();
      end
    end
    for (int b = 0; b <= int'(len); b++) begin
      wvalid = 1; wready = 1; wlast = (b == int'(len)); wdata = d; wstrb = s;
      m_push = hit && r[8];
      m_byte = r[7:0];
      step();
      awvalid = 0; awready = 0;
    end
    wvalid = 0; wready = 0; wlast = 0;
  endtask

  task automatic drain(input int n);
    char_ready = 1;
    repeat (n) step();
    char_ready = 0;
  endtask

  initial begin
    int pops;
    logic [15:0] strb_tab [4];
    logic [39:0] a;
    logic [15:0] s;
    logic [3:0]  len;
    strb_tab[0] = 16'h000F; strb_tab[1] = 16'h00F0;
    strb_tab[2] = 16'h0F00; strb_tab[3] = 16'hF000;

    // Reset state
    do_reset();
    chk("rst_valid", char_valid, 0);
    chk("rst_data", char_data, 0);
    chk("rst_done", status_done, 0);
    chk("rst_pass", status_pass, 0);
    chk("rst_code", fail_code, 0);
    chk("rst_drop", drop_cnt, 0);

    // Separate AW then W, strobe 00F0
    cw({8'h00, CON}, 4'd0, 16'h00F0, 128'h41 << 32, 0);
    chk("t1_valid", char_valid, 1);
    chk("t1_data", char_data, 8'h41);
    drain(2);
    chk("t1_empty", char_valid, 0);

    // Same-cycle AW+W "Hi!" and a burst that must not push
    cw({8'h00, CON}, 4'd0, 16'h000F, 128'h48, 1);
    cw({8'h00, CON}, 4'd0, 16'h0F00, 128'h69 << 64, 1);
    cw({8'h00, CON}, 4'd0, 16'hF000, 128'h21 << 96, 1);
    cw({8'h00, CON}, 4'd1, 16'h000F, 128'h55, 1);
    chk("hi_head", char_data, 8'h48);
    drain(4);

    // Fill past capacity, then push+pop while full
    for (int i = 0; i < 18; i++) cw({8'h00, CON}, 4'd0, 16'h000F, 128'(8'h30 + i), 1);
    chk("full_drop", drop_cnt, 2);
    char_ready = 1;
    cw({8'h00, CON}, 4'd0, 16'h0001, 128'h7A, 1);
    char_ready = 0;
    chk("full_pp_drop", drop_cnt, 2);
    pops = 0;
    char_ready = 1;
    for (int i = 0; i < 20; i++) begin
      if (char_valid) pops++;
      step();
    end
    char_ready = 0;
    chk("full_occupancy", pops, 16);

    // Randomized console traffic
    rnd_ready = 1;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(3))
        0: a = {8'h00, CON};
        1: a = {8'hA5, CON};
        2: a = {8'h00, CON ^ (32'h1 << $urandom_range(31))};
        default: a = {8'h00, $urandom};
      endcase
      len = ($urandom_range(3) == 0) ? 4'($urandom_range(2)) : 4'd0;
      case ($urandom_range(5))
        0, 1, 2, 3: s = strb_tab[$urandom_range(3)];
        4: s = 16'h1 << $urandom_range(15);
        default: s = 16'($urandom);
      endcase
      cw(a, len, s, {$urandom, $urandom, $urandom, $urandom}, 1'($urandom));
    end
    rnd_ready = 0;
    drain(20);

    // Reset mid-transaction drops context and FIFO contents
    cw({8'h00, CON}, 4'd0, 16'h000F, 128'h61, 1);
    awvalid = 1; awready = 1; awaddr = {8'h00, CON}; awlen = 0;
    step();
    do_reset();
    chk("midrst_valid", char_valid, 0);
    wvalid = 1; wready = 1; wlast = 1; wstrb = 16'h000F; wdata = 128'h62;
    step();
    wvalid = 0; wready = 0; wlast = 0;
    step();
    chk("orphan_w", char_valid, 0);

    // PASS on wb1, later FAIL ignored
    wb1_vld = 1; wb1_data = PASS;
    step();
    wb1_vld = 0;
    chk("pass_n1_done", status_done, 0);
    step();
    chk("pass_done", status_done, 1);
    chk("pass_pass", status_pass, 1);
    chk("pass_code", fail_code, 0);
    wb0_vld = 1; wb0_data = FAIL;
    step();
    wb0_vld = 0;
    repeat (3) step();
    chk("frozen_pass", status_pass, 1);
    chk("frozen_code", fail_code, 0);

    // PASS wins over FAIL in the same cycle
    do_reset();
    wb0_vld = 1; wb0_data = FAIL; wb1_vld = 1; wb1_data = PASS;
    step();
    wb0_vld = 0; wb1_vld = 0;
    step();
    chk("both_done", status_done, 1);
    chk("both_pass", status_pass, 1);
    chk("both_code", fail_code, 0);

    // FAIL alone
    do_reset();
    wb0_vld = 1; wb0_data = FAIL;
    step();
    wb0_vld = 0;
    chk("fail_n1_done", status_done, 0);
    step();
    chk("fail_done", status_done, 1);
    chk("fail_pass", status_pass, 0);
    chk("fail_code", fail_code, 1);

    // Watchdog fires in cycle 9 with no retire
    retire = 0;
    do_reset();
    repeat (7) step();
    chk("wd_early", status_done, 0);
    step();
    chk("wd_done", status_done, 1);
    chk("wd_code", fail_code, 2);
    chk("wd_pass", status_pass, 0);

    // One retire per window keeps the watchdog quiet
    do_reset();
    for (int i = 0; i < 48; i++) begin
      retire = ((i % 8) == 3);
      step();
      chk("wd_quiet", status_done, 0);
    end
    retire = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sim_console_mon.md
# sim_console_mon

Synthesizable simulation monitor that sits directly downstream of the C906 CPU top's AXI write channels and retire/write-back taps, alongside the AXI slave memory. It decodes single-beat console writes to the print address, extracts the character byte by strobe, and buffers characters in a FIFO drained over a valid/ready port. It also raises sticky pass/fail status from write-back magic values and from a no-retire watchdog, so the bench only has to watch `status_done`.

## Interface
Parameters:
- `CON_ADDR`, 32'h9000_0000, console address, compared against `awaddr[31:0]`
- `FIFO_DEPTH`, 16, character FIFO entries, power of two, ≥2
- `WD_CYC`, 5000000, watchdog window length in cycles, ≥2
- `PASS_VAL`, 64'h0000_0004_4433_3222, write-back pass magic
- `FAIL_VAL`, 64'h0000_0023_8234_8720, write-back fail magic

Ports:
- `clk` in 1 — the block's single clock
- `rst` in 1 — synchronous, active-high reset
- `awvalid`, `awready` in 1 — AXI AW handshake (snooped only)
- `awaddr` in 40 — write address
- `awlen` in 4 — burst length − 1
- `wvalid`, `wready`, `wlast` in 1 — AXI W handshake (snooped only)
- `wdata` in 128 — write data
- `wstrb` in 16 — byte strobes
- `retire` in 1 — one instruction retired this cycle
- `wb0_vld`, `wb1_vld` in 1 — write-back port valids
- `wb0_data`, `wb1_data` in 64 — write-back data
- `char_valid` out 1 — FIFO head valid
- `char_data` out 8 — FIFO head character
- `char_ready` in 1 — consumer accepts head
- `status_done` out 1 — sticky end-of-test
- `status_pass` out 1 — sticky, meaningful only when done
- `fail_code` out 2 — 0 none/pass, 1 magic fail, 2 watchdog
- `drop_cnt` out 16 — saturating count of characters lost to a full FIFO

## Operation
- Address FSM states: IDLE, W_HIT, W_MISS.
  - IDLE: on AW handshake (`awvalid&&awready`), set hit = (`awlen==0` && `awaddr[31:0]==CON_ADDR`), then go to W_HIT if hit, else W_MISS.
  - If a W handshake with `wlast` occurs in the same cycle as the AW handshake, decode it in that cycle and stay in IDLE.
  - W_HIT/W_MISS: return to IDLE on a W handshake with `wlast`.
  - W beats arriving in IDLE with no same-cycle AW are not decoded. The BIU never leads AW with W.
- Character extraction, applied on a W handshake in hit context:
  - `wstrb` 16'h000F → `wdata[7:0]`
  - 16'h00F0 → `[39:32]`
  - 16'h0F00 → `[71:64]`
  - 16'hF000 → `[103:96]`
  - single-bit strobe `1<<k` → byte k
  - any other pattern → no character.
- FIFO push rules:
  - Push the extracted byte.
  - If the FIFO is full and no pop occurs that cycle, drop the byte and increment `drop_cnt`, saturating at 16'hFFFF.
  - Simultaneous push and pop when full: both succeed.
- Pop occurs on `char_valid && char_ready`.
- Write-back taps: register the valid/data pairs one cycle, then compare against the magic values.
  - Registered match on PASS_VAL: `status_done=1`, `status_pass=1`.
  - Registered match on FAIL_VAL: `status_done=1`, `fail_code=1`.
  - PASS wins if both match in the same cycle (either port).
- Watchdog:
  - Window counter runs 0..WD_CYC−1, then wraps.
  - `seen` flag is set by `retire`.
  - On the terminal count, if `seen==0` and `retire==0`, set `status_done=1`, `fail_code=2`.
  - The flag clears at each wrap.
- Once `status_done=1`, all status outputs freeze until reset. Console decode and FIFO drain continue.

## Timing
- Reset values: FSM IDLE; FIFO empty; `char_valid=0`; `char_data=0`; `status_done=0`; `status_pass=0`; `fail_code=0`; `drop_cnt=0`; watchdog counter 0; `seen=0`; write-back registers cleared (valids 0).
- Reset asserted mid-transaction discards any pending AW context and all FIFO contents.
- Console latency: W handshake in cycle N → `char_valid=1` in N+1 (FIFO was empty). `char_data` is registered and stable while `char_valid && !char_ready`.
- Magic latency: write-back match in cycle N → status outputs update in N+2.
- Watchdog: with no retire after reset, done is asserted in cycle WD_CYC+1 after the reset-release edge.
- No backpressure on AXI: `awready`/`wready` are inputs only and the block never stalls the bus.

## Test plan
- AW `awaddr=0x90000000`, `awlen=0`, then W with `wstrb=16'h00F0`, `wdata[39:32]=0x41` → `char_data=0x41`, `char_valid` high one cycle after the W handshake; `char_ready=1` empties the FIFO.
- Same-cycle AW+W with `wstrb=16'h000F` / 16'h0F00 / 16'hF000 carrying "H","i","!" → FIFO outputs 0x48, 0x69, 0x21 in order. `awlen=1` to the same address → no push.
- `char_ready=0`, 18 console writes → 16 entries held, `drop_cnt=2`. Then a push and pop in the same cycle while full → `drop_cnt` stays 2 and occupancy stays 16.
- `wb1_vld=1`, `wb1_data=PASS_VAL` at cycle N → `status_done=1`, `status_pass=1` at N+2. A later FAIL_VAL leaves status unchanged.
- `wb0=FAIL_VAL` and `wb1=PASS_VAL` in the same cycle → pass. `wb0=FAIL_VAL` alone → `fail_code=1`, `status_pass=0`.
- `WD_CYC=8`, `retire` held 0 → `fail_code=2` at cycle 9. A single `retire` pulse in each window → done never asserts.
